// File: rtl/add_sub_chunked_if.sv
// add_sub_chunked_if: start/busy/done handshake, operands and result of the chunked adder/subtractor.
interface add_sub_chunked_if #(parameter int WIDTH = 8);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   modport master (output start, sub, A, B, input busy, done, sum, cout, ovf);
   modport slave (input start, sub, A, B, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/add_sub_chunked.sv
// add_sub_chunked: WIDTH-bit add/sub computed CHUNK bits per cycle with the carry held between cycles.
module add_sub_chunked #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input logic clk,
   input logic rst_n,
   add_sub_chunked_if.slave bus
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, sum_acc, acc_nx, sum_r;
   logic [IW-1:0] idx;
   logic carry, cout_r, ovf_r, last, go;
   logic [CHUNK:0] part;
   always_comb begin
      part = {1'b0, a_r[idx*CHUNK +: CHUNK]} + {1'b0, b_r[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
      acc_nx = sum_acc;
      acc_nx[idx*CHUNK +: CHUNK] = part[CHUNK-1:0];
      last = idx == IW'(NCH - 1);
      go = bus.start && state != RUN;
      state_nx = state == RUN ? (last ? DONE : RUN) : go ? RUN : IDLE;
   end
   // subtraction is A + ~B + 1, the +1 entering as the initial carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_r <= '0;
         b_r <= '0;
         sum_acc <= '0;
         sum_r <= '0;
         idx <= '0;
         carry <= 1'b0;
         cout_r <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         state <= state_nx;
         if (go) begin
            a_r <= bus.A;
            b_r <= bus.sub ? ~bus.B : bus.B;
            carry <= bus.sub;
            idx <= '0;
            sum_acc <= '0;
         end else if (state == RUN) begin
            sum_acc <= acc_nx;
            carry <= part[CHUNK];
            idx <= idx + 1'b1;
            if (last) begin
               sum_r <= acc_nx;
               cout_r <= part[CHUNK];
               ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_nx[WIDTH-1] != a_r[WIDTH-1]);
            end
         end
      end
   end
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.sum = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf = ovf_r;
endmodule
